display_tx: RTL and testbench
=============================

DISPLAY_TX -- requirements
Module: display_tx

Interface
REQ-001 Parameter CLKS_PER_BIT, default 16: clk cycles per serial bit period; legal range 2..65535.
REQ-002 Parameter FIFO_DEPTH, default 8: byte FIFO entries; power of two, 2..64.
REQ-003 clk  input  1  system clock; all state changes on posedge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 dsp_in_en  input  1  write strobe from the controller (OUT instruction); sampled on posedge.
REQ-006 in  input  16  data bus; only in[7:0] is used.
REQ-007 tx  output  1  serial line, idles high.
REQ-008 busy  output  1  high while the FIFO is non-empty or a frame is in progress.
REQ-009 full  output  1  FIFO holds FIFO_DEPTH entries.
REQ-010 overflow  output  1  sticky flag set when a write is dropped.
REQ-011 count  output  7  current FIFO occupancy, 0..FIFO_DEPTH.

Function
REQ-012 A posedge with dsp_in_en=1 and the FIFO not full SHALL push in[7:0]; count SHALL increment after that edge.
REQ-013 Push with full=1 and no pop on the same edge SHALL drop the byte and set overflow; FIFO contents SHALL be unchanged.
REQ-014 Simultaneous push and pop SHALL both take effect, including when full (byte accepted, count unchanged).
REQ-015 FIFO SHALL be first-in first-out; pointers SHALL wrap modulo FIFO_DEPTH.
REQ-016 The transmitter FSM SHALL have the states IDLE, START, DATA, STOP, plus PARITY when configured.
REQ-017 In IDLE with count!=0, the next edge SHALL pop the head byte into the shift register, enter START and drive tx=0.
- Latency: tx falls after the edge following the push edge.
REQ-018 START SHALL last CLKS_PER_BIT cycles, then DATA.
REQ-019 DATA SHALL transmit 8 bits LSB first, each for CLKS_PER_BIT cycles.
REQ-020 STOP SHALL drive tx=1 for CLKS_PER_BIT cycles.
REQ-021 On the last STOP cycle, the FSM SHALL go directly to START (pop and tx=0, no idle gap) if count!=0, else to IDLE.
REQ-022 tx SHALL be driven from a register and be glitch-free; tx=1 in IDLE.
REQ-023 A frame SHALL last exactly 10*CLKS_PER_BIT cycles, or 11*CLKS_PER_BIT cycles with parity.
REQ-024 busy SHALL equal (state!=IDLE) or (count!=0); full SHALL equal (count==FIFO_DEPTH).
REQ-025 Bit-period and bit-index counters SHALL reload at every state transition; the bit-period counter SHALL never exceed CLKS_PER_BIT-1.

Reset
REQ-026 rst=1 SHALL immediately, without waiting for clk, force:
- state=IDLE, tx=1;
- count=0, FIFO pointers=0;
- overflow=0, busy=0, full=0;
- shift register and all counters=0.
REQ-027 Reset mid-frame SHALL abort the frame with tx=1 at once; pending bytes SHALL be discarded.
REQ-028 Writes while rst=1 SHALL be ignored.
REQ-029 overflow SHALL be cleared only by reset.

Configuration
REQ-030 Macro DISPLAY_TX_PARITY_EN defined: the PARITY state SHALL follow DATA and transmit the even-parity bit (XOR of the 8 data bits) for CLKS_PER_BIT cycles before STOP.
REQ-031 Macro DISPLAY_TX_PARITY_EN undefined: the PARITY state and its logic SHALL be absent and the frame SHALL be 8N1.

Verification (CLKS_PER_BIT=4, FIFO_DEPTH=8)
REQ-032 Reset, then 20 idle cycles -> tx=1, busy=0, count=0, overflow=0 throughout.
REQ-033 One write of in=16'h1255 -> tx falls one edge after the write; then 0,1,0,1,0,1,0,1,0 (start + 0x55 LSB first), then stop 1, each held 4 cycles; busy drops after 40 cycles.
REQ-034 Three back-to-back writes 8'h01, 8'h02, 8'h03 -> three contiguous 40-cycle frames, no idle gap, bytes in write order.
REQ-035 Ten writes on consecutive edges of 8'h10..8'h19 -> 8'h10..8'h18 transmitted, 8'h19 dropped, overflow=1, full=1 after the 9th write.
REQ-036 Reset asserted mid-DATA of the second of two queued bytes -> tx=1 without a clk edge, count=0, no further frames.
REQ-037 With DISPLAY_TX_PARITY_EN, write 8'h07 -> parity bit 1 and 44-cycle frame; write 8'h03 -> parity bit 0.

Source files
------------

// File: rtl/display_tx_if.sv
// Controller-side bus of the display transmitter: the write strobe with its
// data word, plus the serial line and the FIFO status flags.
interface display_tx_if;
    logic        dsp_in_en;
    logic [15:0] in;
    logic        tx;
    logic        busy;
    logic        full;
    logic        overflow;
    logic [6:0]  count;

    modport master (
        output dsp_in_en,
        output in,
        input  tx,
        input  busy,
        input  full,
        input  overflow,
        input  count
    );

    modport slave (
        input  dsp_in_en,
        input  in,
        output tx,
        output busy,
        output full,
        output overflow,
        output count
    );
endinterface

// File: rtl/display_tx.sv
// display_tx: byte FIFO feeding an asynchronous serial transmitter
// (start bit, 8 data bits LSB first, optional even parity, stop bit).
// Optional feature macro: DISPLAY_TX_PARITY_EN adds the PARITY state and
// turns the frame from 8N1 into 8E1.
module display_tx #(
    parameter int CLKS_PER_BIT = 16,
    parameter int FIFO_DEPTH   = 8
) (
    input  logic         clk,
    input  logic         rst,
    display_tx_if.slave  bus
);

    localparam int              PTR_W    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int              CNT_W    = 16;
    localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [6:0]      DEPTH_C  = 7'(FIFO_DEPTH);

`ifdef DISPLAY_TX_PARITY_EN
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    // Even parity of a data byte: XOR of all eight bits.
    function automatic logic even_parity(input logic [7:0] d);
        return ^d;
    endfunction
`else
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3
    } state_t;
`endif

    state_t             state_r;
    state_t             state_next_s;
    logic [CNT_W-1:0]   bit_cnt_r;
    logic [CNT_W-1:0]   bit_cnt_next_s;
    logic [2:0]         bit_idx_r;
    logic [2:0]         bit_idx_next_s;
    logic [7:0]         shift_r;
    logic [7:0]         shift_next_s;
    logic               tx_r;
    logic               tx_next_s;
`ifdef DISPLAY_TX_PARITY_EN
    logic               parity_r;
    logic               parity_next_s;
`endif

    logic [7:0]         mem_r [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr_r;
    logic [PTR_W-1:0]   rd_ptr_r;
    logic [6:0]         count_r;
    logic [6:0]         count_next_s;
    logic               busy_r;
    logic               full_r;
    logic               overflow_r;

    logic               pop_s;
    logic               push_s;
    logic               drop_s;
    logic               bit_done_s;
    logic               fifo_nonempty_s;
    logic               fifo_full_s;
    logic [7:0]         head_s;
    logic [7:0]         unused_hi_s;

    // Only the low byte of the data bus carries display data.
    assign unused_hi_s     = bus.in[15:8];

    assign bit_done_s      = (bit_cnt_r == BIT_LAST);
    assign fifo_nonempty_s = (count_r != 7'd0);
    assign fifo_full_s     = (count_r == DEPTH_C);
    assign head_s          = mem_r[rd_ptr_r];

    // A full FIFO still accepts a byte when the transmitter pops on the same edge.
    assign push_s = bus.dsp_in_en & (~fifo_full_s | pop_s);
    assign drop_s = bus.dsp_in_en & fifo_full_s & ~pop_s;

    // Occupancy after this edge, from the push/pop pair.
    always_comb begin
        count_next_s = count_r;
        case ({push_s, pop_s})
            2'b10:   count_next_s = count_r + 7'd1;
            2'b01:   count_next_s = count_r - 7'd1;
            default: count_next_s = count_r;
        endcase
    end

    // FIFO storage; pointer reset alone makes stale entries unreachable.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= bus.in[7:0];
        end
    end

    // FIFO pointers, occupancy and registered status flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_r   <= {PTR_W{1'b0}};
            rd_ptr_r   <= {PTR_W{1'b0}};
            count_r    <= 7'd0;
            busy_r     <= 1'b0;
            full_r     <= 1'b0;
            overflow_r <= 1'b0;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            count_r    <= count_next_s;
            busy_r     <= (state_next_s != IDLE) || (count_next_s != 7'd0);
            full_r     <= (count_next_s == DEPTH_C);
            overflow_r <= overflow_r | drop_s;
        end
    end

    // Transmitter state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Transmitter next-state logic: each non-idle state lasts one bit period.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (fifo_nonempty_s) begin
                    state_next_s = START;
                end else begin
                    state_next_s = IDLE;
                end
            end
            START: begin
                if (bit_done_s) begin
                    state_next_s = DATA;
                end else begin
                    state_next_s = START;
                end
            end
            DATA: begin
                if (bit_done_s && (bit_idx_r == 3'd7)) begin
`ifdef DISPLAY_TX_PARITY_EN
                    state_next_s = PARITY;
`else
                    state_next_s = STOP;
`endif
                end else begin
                    state_next_s = DATA;
                end
            end
`ifdef DISPLAY_TX_PARITY_EN
            PARITY: begin
                if (bit_done_s) begin
                    state_next_s = STOP;
                end else begin
                    state_next_s = PARITY;
                end
            end
`endif
            STOP: begin
                if (bit_done_s && fifo_nonempty_s) begin
                    state_next_s = START;
                end else if (bit_done_s) begin
                    state_next_s = IDLE;
                end else begin
                    state_next_s = STOP;
                end
            end
            default: state_next_s = IDLE;
        endcase
    end

    // Transmitter outputs: pop/load, counters and the next value of the line.
    always_comb begin
        pop_s          = 1'b0;
        tx_next_s      = tx_r;
        bit_cnt_next_s = bit_done_s ? {CNT_W{1'b0}} : (bit_cnt_r + CNT_W'(1));
        bit_idx_next_s = bit_idx_r;
        shift_next_s   = shift_r;
`ifdef DISPLAY_TX_PARITY_EN
        parity_next_s  = parity_r;
`endif
        case (state_r)
            IDLE: begin
                bit_cnt_next_s = {CNT_W{1'b0}};
                bit_idx_next_s = 3'd0;
                if (fifo_nonempty_s) begin
                    pop_s         = 1'b1;
                    shift_next_s  = head_s;
                    tx_next_s     = 1'b0;
`ifdef DISPLAY_TX_PARITY_EN
                    parity_next_s = even_parity(head_s);
`endif
                end else begin
                    tx_next_s = 1'b1;
                end
            end
            START: begin
                if (bit_done_s) begin
                    tx_next_s = shift_r[0];
                end else begin
                    tx_next_s = 1'b0;
                end
            end
            DATA: begin
                if (bit_done_s && (bit_idx_r == 3'd7)) begin
                    bit_idx_next_s = 3'd0;
`ifdef DISPLAY_TX_PARITY_EN
                    tx_next_s      = parity_r;
`else
                    tx_next_s      = 1'b1;
`endif
                end else if (bit_done_s) begin
                    bit_idx_next_s = bit_idx_r + 3'd1;
                    shift_next_s   = {1'b0, shift_r[7:1]};
                    tx_next_s      = shift_r[1];
                end else begin
                    tx_next_s = shift_r[0];
                end
            end
`ifdef DISPLAY_TX_PARITY_EN
            PARITY: begin
                if (bit_done_s) begin
                    tx_next_s = 1'b1;
                end else begin
                    tx_next_s = parity_r;
                end
            end
`endif
            STOP: begin
                if (bit_done_s && fifo_nonempty_s) begin
                    // Back-to-back frame: next start bit follows the stop bit directly.
                    pop_s          = 1'b1;
                    shift_next_s   = head_s;
                    tx_next_s      = 1'b0;
                    bit_idx_next_s = 3'd0;
`ifdef DISPLAY_TX_PARITY_EN
                    parity_next_s  = even_parity(head_s);
`endif
                end else begin
                    tx_next_s = 1'b1;
                end
            end
            default: begin
                tx_next_s      = 1'b1;
                bit_cnt_next_s = {CNT_W{1'b0}};
                bit_idx_next_s = 3'd0;
            end
        endcase
    end

    // Transmitter datapath registers; tx is registered so the line never glitches.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bit_cnt_r <= {CNT_W{1'b0}};
            bit_idx_r <= 3'd0;
            shift_r   <= 8'd0;
            tx_r      <= 1'b1;
`ifdef DISPLAY_TX_PARITY_EN
            parity_r  <= 1'b0;
`endif
        end else begin
            bit_cnt_r <= bit_cnt_next_s;
            bit_idx_r <= bit_idx_next_s;
            shift_r   <= shift_next_s;
            tx_r      <= tx_next_s;
`ifdef DISPLAY_TX_PARITY_EN
            parity_r  <= parity_next_s;
`endif
        end
    end

    assign bus.tx       = tx_r;
    assign bus.busy     = busy_r;
    assign bus.full     = full_r;
    assign bus.overflow = overflow_r;
    assign bus.count    = count_r;

endmodule

// File: tb/tb_display_tx.sv
// Testbench for display_tx: directed scenarios followed by random traffic,
// every cycle compared against a frame-level reference model.
module tb_display_tx;

    localparam int C     = 4;
    localparam int DEPTH = 8;

    logic clk = 1'b0;
    logic rst;
    int   total  = 0;
    int   passed = 0;
    int   failed = 0;

    display_tx_if bus_if ();

    display_tx #(.CLKS_PER_BIT(C), .FIFO_DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    always #5 clk = ~clk;

    // Reference model: queue of bytes waiting, queue of line levels still to
    // be sent for the frame in progress, sticky overflow.
    logic [7:0] q[$];
    bit         lq[$];
    bit         m_ovf;
    bit         m_in_frame;
    bit         m_tx;

    function automatic void model_reset();
        q.delete();
        lq.delete();
        m_ovf      = 1'b0;
        m_in_frame = 1'b0;
        m_tx       = 1'b1;
    endfunction

    function automatic void start_frame(input logic [7:0] b);
        for (int c = 0; c < C; c++) lq.push_back(1'b0);
        for (int i = 0; i < 8; i++)
            for (int c = 0; c < C; c++) lq.push_back(b[i]);
`ifdef DISPLAY_TX_PARITY_EN
        for (int c = 0; c < C; c++) lq.push_back(^b);
`endif
        for (int c = 0; c < C; c++) lq.push_back(1'b1);
    endfunction

    // One clock edge: a new frame starts once the previous one has fully
    // drained, using occupancy from before this edge's write.
    function automatic void model_edge(input bit en, input logic [7:0] d);
        if (lq.size() == 0 && q.size() != 0) start_frame(q.pop_front());
        if (lq.size() != 0) begin
            m_tx       = lq.pop_front();
            m_in_frame = 1'b1;
        end else begin
            m_tx       = 1'b1;
            m_in_frame = 1'b0;
        end
        if (en) begin
            if (q.size() < DEPTH) q.push_back(d);
            else m_ovf = 1'b1;
        end
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic compare_all(input string where);
        check({where, ".tx"},       32'(bus_if.tx),       32'(m_tx));
        check({where, ".busy"},     32'(bus_if.busy),     32'(m_in_frame || (q.size() != 0)));
        check({where, ".count"},    32'(bus_if.count),    32'(q.size()));
        check({where, ".full"},     32'(bus_if.full),     32'(q.size() == DEPTH));
        check({where, ".overflow"}, 32'(bus_if.overflow), 32'(m_ovf));
    endtask

    // Drive inputs at the falling edge, model the rising edge, compare at the next falling edge.
    task automatic tick(input bit en, input logic [15:0] d);
        bus_if.dsp_in_en = en;
        bus_if.in        = d;
        @(posedge clk);
        model_edge(en, d[7:0]);
        @(negedge clk);
        bus_if.dsp_in_en = 1'b0;
        compare_all("tick");
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(1'b0, 16'h0000);
    endtask

    // Reset between clock edges: outputs must settle without any clock edge.
    task automatic async_reset(input bit en_during);
        #2;
        rst              = 1'b1;
        bus_if.dsp_in_en = en_during;
        bus_if.in        = 16'h00AB;
        #1;
        model_reset();
        compare_all("rst_async");
        @(posedge clk);
        @(negedge clk);
        compare_all("rst_hold");
        rst              = 1'b0;
        bus_if.dsp_in_en = 1'b0;
    endtask

    initial begin
        int rate;
        rst              = 1'b1;
        bus_if.dsp_in_en = 1'b0;
        bus_if.in        = 16'h0000;
        model_reset();

        // Reset state, with writes attempted during reset.
        @(negedge clk);
        compare_all("reset");
        bus_if.dsp_in_en = 1'b1;
        bus_if.in        = 16'h00C3;
        @(negedge clk);
        compare_all("reset_write");
        bus_if.dsp_in_en = 1'b0;
        rst              = 1'b0;

        // Idle line after reset.
        idle(20);

        // Single frame of 0x55.
        tick(1'b1, 16'h1255);
        idle(45);

        // Three back-to-back frames.
        tick(1'b1, 16'h0001);
        tick(1'b1, 16'h0002);
        tick(1'b1, 16'h0003);
        idle(130);

        // Ten consecutive writes: ninth fills the FIFO, tenth is dropped.
        for (int i = 0; i < 10; i++) tick(1'b1, 16'(8'h10 + i));
        idle(380);

        // Overflow is only cleared by reset.
        async_reset(1'b0);
        idle(5);

        // Parity-sensitive bytes.
        tick(1'b1, 16'h0007);
        tick(1'b1, 16'h0003);
        idle(100);

        // Reset in the middle of the second queued frame's data bits.
        tick(1'b1, 16'h00A6);
        tick(1'b1, 16'h005B);
        idle(52);
        async_reset(1'b0);
        idle(60);

        // Random traffic with varying write density and occasional resets.
        rate = 20;
        for (int n = 0; n < 1500; n++) begin
            if (n % 150 == 0) rate = int'($urandom_range(2, 70));
            if ($urandom_range(0, 999) < 3) async_reset(bit'($urandom_range(0, 1)));
            else tick(bit'($urandom_range(0, 99) < rate), 16'($urandom));
        end
        idle(400);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
